// File: rtl/regfile_writeback.sv
// Write-side front end of the integer register file.
// Retiring ALU and load results are buffered in a small FIFO and drained one
// entry per cycle onto the register file write port. Pending entries are
// searched combinationally so decode can forward rs1/rs2 values that have not
// yet reached the (registered-read) register file.
module regfile_writeback #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  // ALU producer
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  // Load/store producer
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  // Register file write port
  output logic            readWrite,
  output logic [4:0]      addr_write,
  output logic [XLEN-1:0] write_data,
  // Forwarding lookups
  input  logic [4:0]      addr_rs1,
  output logic            fwd1_hit,
  output logic [XLEN-1:0] fwd1_data,
  input  logic [4:0]      addr_rs2,
  output logic            fwd2_hit,
  output logic [XLEN-1:0] fwd2_data,
  output logic            idle
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  // FIFO storage
  logic [4:0]       r_ent_rd   [DEPTH];
  logic [XLEN-1:0]  r_ent_data [DEPTH];
  logic [DEPTH-1:0] r_ent_valid;
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;

  logic             w_full;
  logic             w_empty;
  logic             w_lsu_fire;
  logic             w_alu_fire;
  logic [4:0]       w_enq_rd;
  logic [XLEN-1:0]  w_enq_data;
  logic             w_push;
  logic             w_pop;
  logic [PtrW-1:0]  w_idx;

  assign w_full  = (r_count == CntW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Handshake: readiness comes from the registered count only; loads win.
  always_comb begin
    lsu_ready  = !rst && !w_full;
    alu_ready  = !rst && !w_full && !lsu_valid;
    w_lsu_fire = lsu_valid && lsu_ready;
    w_alu_fire = alu_valid && alu_ready;
    w_enq_rd   = w_lsu_fire ? lsu_rd   : alu_rd;
    w_enq_data = w_lsu_fire ? lsu_data : alu_data;
    // x0 writes complete the handshake but never occupy a slot
    w_push     = (w_lsu_fire || w_alu_fire) && (w_enq_rd != 5'd0);
    // The register file always accepts, so the head retires every non-empty cycle
    w_pop      = !rst && !w_empty;
  end

  // Write port driven purely from FIFO state.
  always_comb begin
    readWrite  = 1'b0;
    addr_write = '0;
    write_data = '0;
    if (w_pop) begin
      readWrite  = 1'b1;
      addr_write = r_ent_rd[r_rd_ptr];
      write_data = r_ent_data[r_rd_ptr];
    end
  end

  assign idle = w_empty;

  // Forwarding search: walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    w_idx     = r_rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_rd_ptr + PtrW'(i);
      if (!rst && r_ent_valid[w_idx]) begin
        if (addr_rs1 != 5'd0 && r_ent_rd[w_idx] == addr_rs1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = r_ent_data[w_idx];
        end
        if (addr_rs2 != 5'd0 && r_ent_rd[w_idx] == addr_rs2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = r_ent_data[w_idx];
        end
      end
    end
  end

  // Control state: pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_ent_valid <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr              <= r_rd_ptr + 1'b1;
        r_ent_valid[r_rd_ptr] <= 1'b0;
      end
      // Push and pop never target the same slot: pop needs count>0 and push
      // needs count<DEPTH, so wr_ptr != rd_ptr whenever both happen.
      if (w_push) begin
        r_wr_ptr              <= r_wr_ptr + 1'b1;
        r_ent_valid[r_wr_ptr] <= 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage; contents are meaningless unless the valid bit is set.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ent_rd[r_wr_ptr]   <= w_enq_rd;
      r_ent_data[r_wr_ptr] <= w_enq_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full))
    else $error("regfile_writeback: enqueue into full FIFO");

  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(w_pop && w_empty))
    else $error("regfile_writeback: dequeue from empty FIFO");

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_writeback;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid, alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            lsu_valid, lsu_ready;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            readWrite;
  logic [4:0]      addr_write;
  logic [XLEN-1:0] write_data;
  logic [4:0]      addr_rs1, addr_rs2;
  logic            fwd1_hit, fwd2_hit;
  logic [XLEN-1:0] fwd1_data, fwd2_data;
  logic            idle;

  always #5 clk = ~clk;

  regfile_writeback #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .lsu_valid  (lsu_valid),
    .lsu_ready  (lsu_ready),
    .lsu_rd     (lsu_rd),
    .lsu_data   (lsu_data),
    .readWrite  (readWrite),
    .addr_write (addr_write),
    .write_data (write_data),
    .addr_rs1   (addr_rs1),
    .fwd1_hit   (fwd1_hit),
    .fwd1_data  (fwd1_data),
    .addr_rs2   (addr_rs2),
    .fwd2_hit   (fwd2_hit),
    .fwd2_data  (fwd2_data),
    .idle       (idle)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t q[$];          // pending writes, oldest first
  int   total = 0;
  int   bad   = 0;
  bit   cmp_en = 1'b0;
  bit   lsu_taken = 1'b0;
  bit   alu_taken = 1'b0;
  bit   m_full, m_lfire, m_afire;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one retire per non-empty cycle, at most one accept, loads first.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      lsu_taken = 1'b0;
      alu_taken = 1'b0;
    end else begin
      m_full  = (q.size() >= DEPTH);
      m_lfire = lsu_valid && !m_full;
      m_afire = alu_valid && !m_full && !lsu_valid;
      if (q.size() > 0) q.delete(0);
      if (m_lfire && lsu_rd != 5'd0) q.push_back('{rd: lsu_rd, data: lsu_data});
      else if (m_afire && alu_rd != 5'd0) q.push_back('{rd: alu_rd, data: alu_data});
      lsu_taken = m_lfire;
      alu_taken = m_afire;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : cmp
    logic            e_we, e_h1, e_h2;
    logic [4:0]      e_addr;
    logic [XLEN-1:0] e_data, e_d1, e_d2;
    if (cmp_en) begin
      e_we   = (q.size() > 0);
      e_addr = e_we ? q[0].rd : 5'd0;
      e_data = e_we ? q[0].data : '0;
      e_h1 = 1'b0; e_d1 = '0; e_h2 = 1'b0; e_d2 = '0;
      for (int k = 0; k < q.size(); k++) begin
        if (addr_rs1 != 5'd0 && q[k].rd == addr_rs1) begin e_h1 = 1'b1; e_d1 = q[k].data; end
        if (addr_rs2 != 5'd0 && q[k].rd == addr_rs2) begin e_h2 = 1'b1; e_d2 = q[k].data; end
      end
      check("readWrite",  readWrite,  e_we);
      check("addr_write", addr_write, e_addr);
      check("write_data", write_data, e_data);
      check("idle",       idle,       q.size() == 0);
      check("lsu_ready",  lsu_ready,  !rst && q.size() < DEPTH);
      check("alu_ready",  alu_ready,  !rst && q.size() < DEPTH && !lsu_valid);
      check("fwd1_hit",   fwd1_hit,   e_h1);
      check("fwd1_data",  fwd1_data,  e_d1);
      check("fwd2_hit",   fwd2_hit,   e_h2);
      check("fwd2_data",  fwd2_data,  e_d2);
    end
  end

  // Drive one cycle of inputs just after the rising edge.
  task automatic cyc(input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                     input logic av, input logic [4:0] ard, input logic [31:0] ad,
                     input logic [4:0] rs1, input logic [4:0] rs2);
    @(posedge clk);
    #1;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    addr_rs1 = rs1; addr_rs2 = rs2;
  endtask

  initial begin
    rst = 1'b1;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    addr_rs1 = 0; addr_rs2 = 0;
    #3;
    check("rst_idle",      idle,      1'b1);
    check("rst_readWrite", readWrite, 1'b0);
    check("rst_lsu_ready", lsu_ready, 1'b0);
    check("rst_alu_ready", alu_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    // 1: single ALU write, one-cycle latency
    cyc(0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 0); #3;
    check("t1_alu_ready", alu_ready, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0); #3;
    check("t1_we",   readWrite,  1'b1);
    check("t1_addr", addr_write, 5'd5);
    check("t1_data", write_data, 32'hDEADBEEF);
    cyc(0, 0, 0, 0, 0, 0, 0, 0); #3;
    check("t1_we_off", readWrite, 1'b0);
    check("t1_idle",   idle,      1'b1);

    // 2: load beats ALU in the same cycle
    cyc(1, 3, 32'h11, 1, 4, 32'h22, 0, 0); #3;
    check("t2_lsu_ready", lsu_ready, 1'b1);
    check("t2_alu_ready", alu_ready, 1'b0);
    cyc(0, 0, 0, 1, 4, 32'h22, 0, 0); #3;
    check("t2_alu_ready2", alu_ready,  1'b1);
    check("t2_addr3",      addr_write, 5'd3);
    check("t2_data3",      write_data, 32'h11);
    cyc(0, 0, 0, 0, 0, 0, 0, 0); #3;
    check("t2_addr4", addr_write, 5'd4);
    check("t2_data4", write_data, 32'h22);

    // 3: forwarding, youngest wins; same-cycle accept is invisible
    cyc(1, 7, 32'h1, 0, 0, 0, 7, 0); #3;
    check("t3_same_cycle_miss", fwd1_hit, 1'b0);
    cyc(1, 7, 32'h2, 0, 0, 0, 7, 0); #3;
    check("t3_hit_old",  fwd1_hit,  1'b1);
    check("t3_data_old", fwd1_data, 32'h1);
    cyc(0, 0, 0, 0, 0, 0, 7, 0); #3;
    check("t3_hit_young",  fwd1_hit,  1'b1);
    check("t3_data_young", fwd1_data, 32'h2);
    check("t3_x0_miss",    fwd2_hit,  1'b0);

    // 4: ten back-to-back loads, written in order across pointer wraps
    for (int i = 0; i < 10; i++) begin
      cyc(1, 5'(i + 1), 32'h100 + 32'(i), 0, 0, 0, 0, 0); #3;
      check("t4_lsu_ready", lsu_ready, 1'b1);
      if (i > 0) begin
        check("t4_addr", addr_write, 5'(i));
        check("t4_data", write_data, 32'h100 + 32'(i - 1));
      end
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0); #3;
    check("t4_addr_last", addr_write, 5'd10);
    check("t4_data_last", write_data, 32'h109);

    // 5: x0 write is accepted and dropped
    cyc(0, 0, 0, 1, 0, 32'hFFFF, 0, 0); #3;
    check("t5_alu_ready", alu_ready, 1'b1);
    check("t5_idle",      idle,      1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0); #3;
    check("t5_idle2", idle,      1'b1);
    check("t5_we",    readWrite, 1'b0);

    // 6: reset asserted mid-cycle with writes pending
    cyc(1, 9, 32'hAA, 0, 0, 0, 0, 0);
    cyc(1, 10, 32'hBB, 0, 0, 0, 0, 0);
    #1 rst = 1'b1; lsu_valid = 0;
    #1;
    check("t6_we",        readWrite, 1'b0);
    check("t6_lsu_ready", lsu_ready, 1'b0);
    check("t6_alu_ready", alu_ready, 1'b0);
    check("t6_idle",      idle,      1'b1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0; #3;
    check("t6_idle_after", idle, 1'b1);
    cyc(0, 0, 0, 0, 0, 0, 10, 9); #3;
    check("t6_no_stale", readWrite, 1'b0);
    check("t6_no_fwd",   fwd1_hit,  1'b0);

    // Randomized traffic with producers holding until accepted
    repeat (800) begin
      @(posedge clk);
      #1;
      if (rst) rst = 1'b0;
      if (!(lsu_valid && !lsu_taken)) begin
        lsu_valid = ($urandom % 3 == 0);
        lsu_rd    = 5'($urandom % 8);
        lsu_data  = $urandom;
      end
      if (!(alu_valid && !alu_taken)) begin
        alu_valid = ($urandom % 2 == 0);
        alu_rd    = 5'($urandom % 8);
        alu_data  = $urandom;
      end
      addr_rs1 = 5'($urandom % 8);
      addr_rs2 = 5'($urandom % 8);
      if ($urandom % 60 == 0) begin
        #2;
        rst = 1'b1;
        lsu_valid = 1'b0;
        alu_valid = 1'b0;
      end
    end

    @(posedge clk);
    #1 cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
